// File: rtl/uart_port_arbiter.sv
// uart_port_arbiter: round-robin share of one UART byte port by NUM_REQ requesters, TX and RX scheduled independently; UART valid 1 cycle after grant, ready pulse 1 cycle after UART handshake.
// Requesters hold valid/data until their ready pulse; define UART_ARB_TX_BUF_EN to decouple TX through a TX_BUF_DEPTH-entry FIFO.
module uart_port_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int TX_BUF_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_tx_valid,
    input  logic [8*NUM_REQ-1:0]   req_tx_data,
    output logic [NUM_REQ-1:0]     req_tx_ready,
    input  logic [NUM_REQ-1:0]     req_rx_valid,
    output logic [7:0]             req_rx_data,
    output logic [NUM_REQ-1:0]     req_rx_ready,
    output logic                   uart_in_valid,
    output logic [7:0]             uart_in_data,
    input  logic                   uart_in_ready,
    output logic                   uart_out_valid,
    input  logic [7:0]             uart_out_data,
    input  logic                   uart_out_ready,
    output logic                   tx_idle
);
    localparam int              IW        = $clog2(NUM_REQ);
    localparam logic [IW-1:0]   LAST_INIT = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_BUSY, TX_DONE} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_BUSY, RX_DONE} rx_state_e;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_port_arbiter: NUM_REQ must be in 2..8");
    end
    if (TX_BUF_DEPTH < 2 || (TX_BUF_DEPTH & (TX_BUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_port_arbiter: TX_BUF_DEPTH must be a power of two >= 2");
    end

    // First requester with valid set, searching upward from the one after `last`.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [IW-1:0]    last);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && vld[IW'(idx)]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // ---------------- TX arbitration ----------------
    tx_state_e             tx_state_q, tx_state_d;
    logic [IW-1:0]         tx_last_q, tx_last_d;
    logic [IW-1:0]         tx_grant_q, tx_grant_d;
    logic [NUM_REQ-1:0]    req_tx_ready_q, req_tx_ready_d;
    logic [IW-1:0]         tx_pick;
    logic [7:0]            tx_byte_sel;
    logic                  uart_in_valid_q, uart_in_valid_d;
    logic [7:0]            uart_in_data_q, uart_in_data_d;

    assign tx_pick = rr_pick(req_tx_valid, tx_last_q);

    always_comb begin
        tx_byte_sel = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tx_pick == IW'(i)) tx_byte_sel = req_tx_data[8*i +: 8];
        end
    end

`ifdef UART_ARB_TX_BUF_EN
    localparam int          AW           = $clog2(TX_BUF_DEPTH);
    localparam logic [AW:0] BUF_FULL_CNT = (AW+1)'(TX_BUF_DEPTH);

    typedef enum logic {DR_IDLE, DR_SEND} dr_state_e;

    logic [7:0]    buf_mem_q [TX_BUF_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    dr_state_e     dr_state_q, dr_state_d;
    logic          buf_push, buf_pop, buf_full;

    assign buf_full = (count_q == BUF_FULL_CNT);

    // Grant side: the byte is parked in tx_byte_q, pushed in BUSY, acknowledged in DONE.
    always_comb begin
        tx_state_d     = tx_state_q;
        tx_last_d      = tx_last_q;
        tx_grant_d     = tx_grant_q;
        tx_byte_d      = tx_byte_q;
        req_tx_ready_d = '0;
        buf_push       = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (|req_tx_valid && !buf_full) begin
                    tx_grant_d = tx_pick;
                    tx_byte_d  = tx_byte_sel;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                buf_push                   = 1'b1;
                req_tx_ready_d[tx_grant_q] = 1'b1;
                tx_last_d                  = tx_grant_q;
                tx_state_d                 = TX_DONE;
            end
            TX_DONE: tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        dr_state_d      = dr_state_q;
        uart_in_valid_d = uart_in_valid_q;
        uart_in_data_d  = uart_in_data_q;
        buf_pop         = 1'b0;
        case (dr_state_q)
            DR_IDLE: begin
                if (count_q != '0) begin
                    uart_in_data_d  = buf_mem_q[rd_ptr_q];
                    uart_in_valid_d = 1'b1;
                    dr_state_d      = DR_SEND;
                end
            end
            DR_SEND: begin
                if (uart_in_ready) begin
                    buf_pop         = 1'b1;
                    uart_in_valid_d = 1'b0;
                    dr_state_d      = DR_IDLE;
                end
            end
            default: dr_state_d = DR_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = buf_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = buf_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(buf_push) - (AW+1)'(buf_pop);
    end

    always_ff @(posedge clk) begin
        if (buf_push) buf_mem_q[wr_ptr_q] <= tx_byte_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q      <= TX_IDLE;
            tx_last_q       <= LAST_INIT;
            tx_grant_q      <= '0;
            tx_byte_q       <= 8'h00;
            req_tx_ready_q  <= '0;
            dr_state_q      <= DR_IDLE;
            uart_in_valid_q <= 1'b0;
            uart_in_data_q  <= 8'h00;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            tx_state_q      <= tx_state_d;
            tx_last_q       <= tx_last_d;
            tx_grant_q      <= tx_grant_d;
            tx_byte_q       <= tx_byte_d;
            req_tx_ready_q  <= req_tx_ready_d;
            dr_state_q      <= dr_state_d;
            uart_in_valid_q <= uart_in_valid_d;
            uart_in_data_q  <= uart_in_data_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    assign tx_idle = (count_q == '0) && (dr_state_q == DR_IDLE);
`else
    always_comb begin
        tx_state_d      = tx_state_q;
        tx_last_d       = tx_last_q;
        tx_grant_d      = tx_grant_q;
        uart_in_valid_d = uart_in_valid_q;
        uart_in_data_d  = uart_in_data_q;
        req_tx_ready_d  = '0;
        case (tx_state_q)
            TX_IDLE: begin
                if (|req_tx_valid) begin
                    tx_grant_d      = tx_pick;
                    uart_in_data_d  = tx_byte_sel;
                    uart_in_valid_d = 1'b1;
                    tx_state_d      = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (uart_in_ready) begin
                    uart_in_valid_d            = 1'b0;
                    req_tx_ready_d[tx_grant_q] = 1'b1;
                    tx_last_d                  = tx_grant_q;
                    tx_state_d                 = TX_DONE;
                end
            end
            TX_DONE: tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q      <= TX_IDLE;
            tx_last_q       <= LAST_INIT;
            tx_grant_q      <= '0;
            uart_in_valid_q <= 1'b0;
            uart_in_data_q  <= 8'h00;
            req_tx_ready_q  <= '0;
        end else begin
            tx_state_q      <= tx_state_d;
            tx_last_q       <= tx_last_d;
            tx_grant_q      <= tx_grant_d;
            uart_in_valid_q <= uart_in_valid_d;
            uart_in_data_q  <= uart_in_data_d;
            req_tx_ready_q  <= req_tx_ready_d;
        end
    end

    assign tx_idle = (tx_state_q == TX_IDLE) && !uart_in_valid_q;
`endif

    assign uart_in_valid = uart_in_valid_q;
    assign uart_in_data  = uart_in_data_q;
    assign req_tx_ready  = req_tx_ready_q;

    // ---------------- RX arbitration (own pointer, never blocked by TX) ----------------
    rx_state_e             rx_state_q, rx_state_d;
    logic [IW-1:0]         rx_last_q, rx_last_d;
    logic [IW-1:0]         rx_grant_q, rx_grant_d;
    logic [NUM_REQ-1:0]    req_rx_ready_q, req_rx_ready_d;
    logic [7:0]            req_rx_data_q, req_rx_data_d;
    logic                  uart_out_valid_q, uart_out_valid_d;
    logic [IW-1:0]         rx_pick;

    assign rx_pick = rr_pick(req_rx_valid, rx_last_q);

    always_comb begin
        rx_state_d       = rx_state_q;
        rx_last_d        = rx_last_q;
        rx_grant_d       = rx_grant_q;
        uart_out_valid_d = uart_out_valid_q;
        req_rx_data_d    = req_rx_data_q;
        req_rx_ready_d   = '0;
        case (rx_state_q)
            RX_IDLE: begin
                if (|req_rx_valid) begin
                    rx_grant_d       = rx_pick;
                    uart_out_valid_d = 1'b1;
                    rx_state_d       = RX_BUSY;
                end
            end
            RX_BUSY: begin
                if (uart_out_ready) begin
                    uart_out_valid_d           = 1'b0;
                    req_rx_data_d              = uart_out_data;
                    req_rx_ready_d[rx_grant_q] = 1'b1;
                    rx_last_d                  = rx_grant_q;
                    rx_state_d                 = RX_DONE;
                end
            end
            RX_DONE: rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q       <= RX_IDLE;
            rx_last_q        <= LAST_INIT;
            rx_grant_q       <= '0;
            uart_out_valid_q <= 1'b0;
            req_rx_data_q    <= 8'h00;
            req_rx_ready_q   <= '0;
        end else begin
            rx_state_q       <= rx_state_d;
            rx_last_q        <= rx_last_d;
            rx_grant_q       <= rx_grant_d;
            uart_out_valid_q <= uart_out_valid_d;
            req_rx_data_q    <= req_rx_data_d;
            req_rx_ready_q   <= req_rx_ready_d;
        end
    end

    assign uart_out_valid = uart_out_valid_q;
    assign req_rx_data    = req_rx_data_q;
    assign req_rx_ready   = req_rx_ready_q;

endmodule
